// File: rtl/bmw_pkg.sv
// +----------------------------------------------------------------------+
// | bmw_pkg : shared types and defaults for the BMW-tree root controller  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package bmw_pkg;

   localparam int PTW_DEF = 16;
   localparam int MTW_DEF = 32;

   // Entries keep priority in the LSBs so a plain slice yields the key.
   typedef struct packed {
      logic [MTW_DEF-1:0] meta;
      logic [PTW_DEF-1:0] prio;
   } bmw_entry_t;

   localparam logic [PTW_DEF-1:0] PRIO_EMPTY = '1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } bmw_state_t;

   typedef enum logic [0:0] {
      SRV_POP  = 1'b0,
      SRV_PUSH = 1'b1
   } bmw_side_t;

endpackage

`default_nettype wire

// File: rtl/bmw_root_ctrl_if.sv
// +----------------------------------------------------------------------+
// | bmw_root_ctrl_if : client push/pop streams and root-node strobe bus   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface bmw_root_ctrl_if #(
   parameter int PTW = 16,
   parameter int MTW = 32
);
   localparam int DW = MTW + PTW;

   logic          i_push_valid;
   logic          o_push_ready;
   logic [DW-1:0] i_push_data;
   logic          i_pop_valid;
   logic          o_pop_ready;
   logic          o_pop_valid;
   logic [DW-1:0] o_pop_data;
   logic          o_node_push;
   logic [DW-1:0] o_node_push_data;
   logic          o_node_pop;
   logic [DW-1:0] i_node_pop_data;

   modport master (
      output i_push_valid, i_push_data, i_pop_valid, i_node_pop_data,
      input  o_push_ready, o_pop_ready, o_pop_valid, o_pop_data,
      input  o_node_push, o_node_push_data, o_node_pop
   );

   modport slave (
      input  i_push_valid, i_push_data, i_pop_valid, i_node_pop_data,
      output o_push_ready, o_pop_ready, o_pop_valid, o_pop_data,
      output o_node_push, o_node_push_data, o_node_pop
   );
endinterface

`default_nettype wire

// File: rtl/bmw_rr_arb2.sv
// +----------------------------------------------------------------------+
// | bmw_rr_arb2 : two-way round-robin grant (pop vs push)                 |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module bmw_rr_arb2
   import bmw_pkg::*;
(
   input  wire  i_clk,
   input  wire  i_arst_n,
   input  wire  i_en,
   input  wire  i_req_pop,
   input  wire  i_req_push,
   output logic o_gnt_pop,
   output logic o_gnt_push
);

   bmw_side_t r_last;
   logic      w_gnt_pop;
   logic      w_gnt_push;

   // On contention the side that was not served last wins.
   always_comb begin
      w_gnt_pop  = i_en & i_req_pop & (~i_req_push | (r_last == SRV_PUSH));
      w_gnt_push = i_en & i_req_push & ~w_gnt_pop;
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_last <= SRV_PUSH;
      end else if (w_gnt_pop) begin
         r_last <= SRV_POP;
      end else if (w_gnt_push) begin
         r_last <= SRV_PUSH;
      end
   end

   assign o_gnt_pop  = w_gnt_pop;
   assign o_gnt_push = w_gnt_push;

endmodule

`default_nettype wire

// File: rtl/bmw_root_ctrl.sv
// +----------------------------------------------------------------------+
// | bmw_root_ctrl : command stage for the 4-way BMW-tree root node        |
// | Optional stats counters: define BMW_ROOT_CTRL_STATS_EN               |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module bmw_root_ctrl
   import bmw_pkg::*;
#(
   parameter int PTW = PTW_DEF,
   parameter int MTW = MTW_DEF,
   parameter int CAP = 1020,
   parameter int OCW = 11,
   parameter int GAP = 1
)(
   input  wire              i_clk,
   input  wire              i_arst_n,
   bmw_root_ctrl_if.slave   bus,
   output logic [OCW-1:0]   o_count,
   output logic             o_empty,
   output logic             o_full
`ifdef BMW_ROOT_CTRL_STATS_EN
   ,
   output logic [31:0]      o_stat_push,
   output logic [31:0]      o_stat_pop,
   output logic [15:0]      o_stat_drop
`endif
);

   localparam int             DW    = MTW + PTW;
   localparam logic [2:0]     c_GAP = 3'(GAP);
   localparam logic [OCW-1:0] c_CAP = OCW'(CAP);

   bmw_state_t     r_state;
   bmw_state_t     w_state_nxt;
   logic [2:0]     r_gap;
   logic [2:0]     w_gap_nxt;
   logic [OCW-1:0] r_count;
   logic           r_node_push;
   logic [DW-1:0]  r_node_push_data;
   logic           r_node_pop;
   logic           r_pop_valid;
   logic [DW-1:0]  r_pop_data;

   logic w_idle;
   logic w_pop_ok;
   logic w_push_ok;
   logic w_gnt_pop;
   logic w_gnt_push;
   logic w_sentinel;
   logic w_do_push;

   assign o_count    = r_count;
   assign o_empty    = (r_count == '0);
   assign o_full     = (r_count == c_CAP);
   assign w_idle     = (r_state == ST_IDLE);
   assign w_pop_ok   = bus.i_pop_valid & ~o_empty;
   assign w_push_ok  = bus.i_push_valid & ~o_full;
   assign w_sentinel = &bus.i_push_data[PTW-1:0];
   // A sentinel push completes its handshake but never reaches the node.
   assign w_do_push  = w_gnt_push & ~w_sentinel;

   bmw_rr_arb2 u_arb (
      .i_clk      (i_clk),
      .i_arst_n   (i_arst_n),
      .i_en       (w_idle),
      .i_req_pop  (w_pop_ok),
      .i_req_push (w_push_ok),
      .o_gnt_pop  (w_gnt_pop),
      .o_gnt_push (w_gnt_push)
   );

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state <= ST_IDLE;
         r_gap   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gap   <= w_gap_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_pop | w_gnt_push) begin
               w_state_nxt = ST_WAIT;
               w_gap_nxt   = c_GAP;
            end
         end
         ST_WAIT: begin
            if (r_gap <= 3'd1) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_gap_nxt = r_gap - 3'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The popped value is captured on the handshake edge; the node pop
   // strobe follows one cycle later so the node advances after capture.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_count          <= '0;
         r_node_push      <= 1'b0;
         r_node_push_data <= '0;
         r_node_pop       <= 1'b0;
         r_pop_valid      <= 1'b0;
         r_pop_data       <= '0;
      end else begin
         r_node_push <= w_do_push;
         r_node_pop  <= w_gnt_pop;
         r_pop_valid <= w_gnt_pop;
         if (w_do_push) begin
            r_node_push_data <= bus.i_push_data;
            r_count          <= r_count + 1'b1;
         end else if (w_gnt_pop) begin
            r_count <= r_count - 1'b1;
         end
         if (w_gnt_pop) begin
            r_pop_data <= bus.i_node_pop_data;
         end
      end
   end

   assign bus.o_push_ready     = w_gnt_push;
   assign bus.o_pop_ready      = w_gnt_pop;
   assign bus.o_pop_valid      = r_pop_valid;
   assign bus.o_pop_data       = r_pop_data;
   assign bus.o_node_push      = r_node_push;
   assign bus.o_node_push_data = r_node_push_data;
   assign bus.o_node_pop       = r_node_pop;

`ifdef BMW_ROOT_CTRL_STATS_EN
   logic [31:0] r_stat_push;
   logic [31:0] r_stat_pop;
   logic [15:0] r_stat_drop;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_stat_push <= '0;
         r_stat_pop  <= '0;
         r_stat_drop <= '0;
      end else begin
         if (w_do_push && (r_stat_push != '1)) r_stat_push <= r_stat_push + 1'b1;
         if (w_gnt_pop && (r_stat_pop != '1))  r_stat_pop  <= r_stat_pop + 1'b1;
         if (w_gnt_push && w_sentinel && (r_stat_drop != '1)) r_stat_drop <= r_stat_drop + 1'b1;
      end
   end

   assign o_stat_push = r_stat_push;
   assign o_stat_pop  = r_stat_pop;
   assign o_stat_drop = r_stat_drop;
`endif

endmodule

`default_nettype wire

// File: doc/bmw_root_ctrl.md
Name: bmw_root_ctrl

Overview:
- Upstream command stage for the 4-way BMW-tree priority-queue root node.
- Converts independent client push and pop valid/ready streams into single-cycle push/pop strobes on the root node.
- Never issues a push and a pop to the node in the same cycle; inserts a fixed settle gap after every operation.
- Tracks total occupancy and returns popped entries to the client with a registered valid pulse.

Parameters:
- PTW, 16, priority field width; all-ones priority is the empty sentinel.
- MTW, 32, metadata field width; entry = {metadata, priority}, priority in LSBs.
- CAP, 1020, maximum number of entries the attached tree holds.
- OCW, 11, occupancy counter width; must satisfy 2^OCW > CAP.
- GAP, 1, idle cycles forced after each issued operation (1..7).

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  reset, asynchronous, active-low
- i_push_valid  in  1  client push request
- o_push_ready  out  1  push accepted this cycle when high with valid
- i_push_data  in  MTW+PTW  client entry
- i_pop_valid  in  1  client pop request
- o_pop_ready  out  1  pop accepted this cycle when high with valid
- o_pop_valid  out  1  one-cycle pulse, popped entry on o_pop_data
- o_pop_data  out  MTW+PTW  popped entry, held until next pop
- o_node_push  out  1  push strobe to root node
- o_node_push_data  out  MTW+PTW  entry to root node
- o_node_pop  out  1  pop strobe to root node
- i_node_pop_data  in  MTW+PTW  root node's current minimum, combinational from node
- o_count  out  OCW  current occupancy
- o_empty  out  1  o_count == 0
- o_full  out  1  o_count == CAP

Behaviour:
- Reset: state IDLE; o_count=0; o_pop_valid=0; o_pop_data=0; node strobes=0; o_node_push_data=0; last_served=PUSH (first contended grant goes to pop); o_empty=1; o_full=0.
- FSM has two states, IDLE and WAIT.
  - IDLE: at most one grant per cycle. Granting moves the FSM to WAIT with gap_cnt=GAP.
  - WAIT: both readies are low; gap_cnt decrements each cycle; return to IDLE when gap_cnt reaches 1.
- Eligibility:
  - pop_ok = i_pop_valid & ~o_empty.
  - push_ok = i_push_valid & ~o_full.
- Arbitration when pop_ok and push_ok are both true: serve the opposite of last_served, then update last_served. When only one is true, serve it.
- Readies are combinational and only high in IDLE for the granted side.
  - o_pop_ready is 0 while empty; the request stalls, it is not dropped.
  - o_push_ready is 0 while full.
- Push grant:
  - o_node_push=1 and o_node_push_data=i_push_data are registered, so they are visible on the node one cycle after the handshake, for exactly 1 cycle.
  - o_count increments in that issue cycle.
- Sentinel push (priority == all-ones): handshake completes (ready=1), but no node strobe is issued, o_count is unchanged, and the FSM still enters WAIT.
- Pop grant:
  - i_node_pop_data is sampled at the handshake edge into o_pop_data; o_pop_valid=1 the next cycle. Latency = 1 cycle.
  - o_node_pop=1 is issued that same next cycle, so the node advances after the value has been captured.
  - o_count decrements in the issue cycle.
- Throughput: one operation per GAP+1 cycles.
- o_count never wraps: increment is blocked at CAP and decrement is blocked at 0 by eligibility.
- Asynchronous reset mid-operation drops any in-flight strobe and pending pop response immediately.

Optional Feature:
- Macro: BMW_ROOT_CTRL_STATS_EN.
- When defined, three outputs are added:
  - o_stat_push 32-bit, counts issued node pushes.
  - o_stat_pop 32-bit, counts issued node pops.
  - o_stat_drop 16-bit, counts sentinel pushes.
- All three counters saturate and reset to 0.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package bmw_pkg:
  - PTW/MTW defaults.
  - Entry typedef {meta, prio}.
  - PRIO_EMPTY constant (all-ones).
  - FSM state enum {IDLE, WAIT}.
- One natural sub-module: bmw_rr_arb2, a 2-input round-robin grant with last_served register.

Test Plan:
- Reset, then push prio 5, 3, 9 (GAP=1) -> node strobes 2 cycles apart; o_count=3. Three pops -> o_pop_data prios 3, 5, 9; o_pop_valid one cycle after each handshake.
- Pop while empty -> o_pop_ready=0 for 10 cycles, no node strobe. Then push prio 7 -> pop completes with prio 7, o_count=0.
- CAP=4: push 5 entries back-to-back -> 5th stalls with o_full=1. One pop -> 5th is accepted after the gap.
- Simultaneous push and pop valid with count=2 -> grants alternate pop, push, pop, push; o_node_push and o_node_pop are never high together.
- Push prio 16'hFFFF -> ready=1, no o_node_push, o_count unchanged. With STATS_EN, o_stat_drop=1.
- Assert i_arst_n low on the cycle after a pop handshake -> o_pop_valid, o_node_pop and o_count all read 0; FSM restarts in IDLE.
